// File: rtl/cmd_frame_pkg.sv
// Shared types and constants for the PC command frame parser.
// Frames are HEADER, LEN, LEN payload bytes, CHK (XOR of LEN and payload).
package cmd_frame_pkg;

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

  // States in which the inter-byte timeout counter runs.
  function automatic logic isFrameState(input state_t s);
    return (s == S_LEN) || (s == S_PAYLOAD) || (s == S_CHK);
  endfunction

endpackage

// File: rtl/cmd_frame_buf.sv
// Payload register file: one synchronous write port, one asynchronous read port.
// No reset; contents are only read back after a full frame has been written.
module cmd_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [7:0]    wrData,
  input  logic [AW-1:0] rdAddr,
  output logic [7:0]    rdData
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/cmd_frame_parser.sv
// Assembles HEADER/LEN/payload/CHK frames from the UART byte stream and forwards
// only checksum-verified payload bytes; bad, oversize or stalled frames are dropped.
module cmd_frame_parser
  import cmd_frame_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = 16,
  parameter logic [7:0] HEADER_BYTE    = DEFAULT_HEADER,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  output logic       rx_ack,
  output logic [7:0] out_data,
  output logic       out_vld,
  input  logic       out_rdy,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output state_t     dbgState
);

  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]    MAX_LEN  = 8'(MAX_PAYLOAD);

  // Handshakes: input side takes a byte in any cycle with rx_rdy=1, rx_ack=0 and
  // state != DRAIN, then pulses rx_ack for exactly one cycle (that cycle is a guard).
  // Output side is valid/ready: a beat moves when out_vld && out_rdy, and
  // out_vld/out_data hold steady until it does.

  state_t        state, stateNext;
  logic [7:0]    lenQ, lenNext;
  logic [7:0]    idxQ, idxNext;
  logic [7:0]    xorQ, xorNext;
  logic [TW-1:0] toCnt, toCntNext;
  logic          rxAckQ, frameOkQ, frameErrQ;
  logic [1:0]    errCodeQ;

  logic          accept;
  logic          inFrame;
  logic          toHit;
  logic          bufWe;
  logic          okSet;
  logic          errSet;
  logic [1:0]    errVal;
  logic [7:0]    lastIdx;
  logic [7:0]    bufRdData;

  assign inFrame = isFrameState(state);
  assign toHit   = inFrame && (toCnt == TO_LIMIT);
  assign accept  = rx_rdy && !rxAckQ && (state != S_DRAIN) && !toHit;
  assign lastIdx = lenQ - 8'd1;

  always_comb begin
    stateNext = state;
    lenNext   = lenQ;
    idxNext   = idxQ;
    xorNext   = xorQ;
    bufWe     = 1'b0;
    okSet     = 1'b0;
    errSet    = 1'b0;
    errVal    = ERR_NONE;

    if (toHit) begin
      errSet    = 1'b1;
      errVal    = ERR_TIMEOUT;
      stateNext = S_HUNT;
    end else begin
      case (state)
        S_HUNT: begin
          if (accept && (rx_data == HEADER_BYTE)) begin
            stateNext = S_LEN;
          end
        end
        S_LEN: begin
          if (accept) begin
            if ((rx_data == 8'd0) || (rx_data > MAX_LEN)) begin
              errSet    = 1'b1;
              errVal    = ERR_LEN;
              stateNext = S_HUNT;
            end else begin
              lenNext   = rx_data;
              xorNext   = rx_data;
              idxNext   = 8'd0;
              stateNext = S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            bufWe   = 1'b1;
            xorNext = xorQ ^ rx_data;
            if (idxQ == lastIdx) begin
              idxNext   = 8'd0;
              stateNext = S_CHK;
            end else begin
              idxNext = idxQ + 8'd1;
            end
          end
        end
        S_CHK: begin
          if (accept) begin
            if (rx_data == xorQ) begin
              okSet     = 1'b1;
              idxNext   = 8'd0;
              stateNext = S_DRAIN;
            end else begin
              errSet    = 1'b1;
              errVal    = ERR_CHK;
              stateNext = S_HUNT;
            end
          end
        end
        S_DRAIN: begin
          if (out_rdy) begin
            if (idxQ == lastIdx) begin
              idxNext   = 8'd0;
              stateNext = S_HUNT;
            end else begin
              idxNext = idxQ + 8'd1;
            end
          end
        end
        default: stateNext = S_HUNT;
      endcase
    end

    // Inter-byte counter only runs while a frame is being received.
    toCntNext = '0;
    if (inFrame && !accept && !toHit) begin
      toCntNext = (toCnt == TO_LIMIT) ? toCnt : toCnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_HUNT;
      lenQ      <= 8'd0;
      idxQ      <= 8'd0;
      xorQ      <= 8'd0;
      toCnt     <= '0;
      rxAckQ    <= 1'b0;
      frameOkQ  <= 1'b0;
      frameErrQ <= 1'b0;
      errCodeQ  <= ERR_NONE;
    end else begin
      state     <= stateNext;
      lenQ      <= lenNext;
      idxQ      <= idxNext;
      xorQ      <= xorNext;
      toCnt     <= toCntNext;
      rxAckQ    <= accept;
      frameOkQ  <= okSet;
      frameErrQ <= errSet;
      if (errSet) begin
        errCodeQ <= errVal;
      end
    end
  end

  cmd_frame_buf #(
    .DEPTH (MAX_PAYLOAD),
    .AW    (AW)
  ) u_buf (
    .clk    (clk),
    .wrEn   (bufWe),
    .wrAddr (idxQ[AW-1:0]),
    .wrData (rx_data),
    .rdAddr (idxQ[AW-1:0]),
    .rdData (bufRdData)
  );

  // Outputs decode from state so an async reset clears them at once.
  assign out_vld   = (state == S_DRAIN);
  assign out_data  = out_vld ? bufRdData : 8'h00;
  assign rx_ack    = rxAckQ;
  assign frame_ok  = frameOkQ;
  assign frame_err = frameErrQ;
  assign err_code  = errCodeQ;
  assign dbgState  = state;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Randomised scoreboard bench for cmd_frame_parser: a frame-level model predicts
// payload bytes and ok/error events, a monitor compares them as the DUT emits them.
module tb_cmd_frame_parser;
  import cmd_frame_pkg::*;

  localparam int         MAXP   = 16;
  localparam int         TO_CYC = 300;
  localparam logic [7:0] HDR    = 8'hAA;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_rdy = 1'b0;
  logic       rx_ack;
  logic [7:0] out_data;
  logic       out_vld;
  logic       out_rdy = 1'b1;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  state_t     dbg_state;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];   // expected payload beats
  logic [1:0] evt_q[$];   // expected events: 0 = frame_ok, 1..3 = frame_err with that code
  logic       pat_q[$];   // out_rdy pattern applied during DRAIN
  int         rdy_mode = 0;

  cmd_frame_parser #(
    .MAX_PAYLOAD    (MAXP),
    .HEADER_BYTE    (HDR),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .rx_ack    (rx_ack),
    .out_data  (out_data),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .dbgState  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    fails++;
    $display("FAIL watchdog: got no end of test, required finish before time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    tests++;
    fails++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Frame-level reference: walk the byte list from HUNT and predict the outcome.
  function automatic void model_stream(input logic [7:0] s[$]);
    int         i = 0;
    int         len;
    logic [7:0] x;
    logic [7:0] pay[$];
    while (i < s.size()) begin
      if (s[i] != HDR) begin
        i++;
        continue;
      end
      i++;
      if (i >= s.size()) break;
      len = int'(s[i]);
      i++;
      if (len == 0 || len > MAXP) begin
        evt_q.push_back(2'd1);
        continue;
      end
      if (i + len >= s.size()) break;
      x = 8'(len);
      pay = {};
      for (int k = 0; k < len; k++) begin
        pay.push_back(s[i + k]);
        x = x ^ s[i + k];
      end
      i += len;
      if (s[i] == x) begin
        evt_q.push_back(2'd0);
        foreach (pay[k]) exp_q.push_back(pay[k]);
      end else begin
        evt_q.push_back(2'd2);
      end
      i++;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    rx_data = b;
    rx_rdy  = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rx_ack && n < 20000);
    if (!rx_ack) fail_now("rx_ack_wait", "got no rx_ack, required one within 20000 cycles");
    rx_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] s[$]);
    model_stream(s);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || evt_q.size() != 0 || out_vld) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) begin
      fail_now("idle_wait", $sformatf("got %0d beats / %0d events pending, required 0",
                                      exp_q.size(), evt_q.size()));
      exp_q = {};
      evt_q = {};
    end
  endtask

  // out_rdy: 0 = always ready, 1 = random, 2 = scripted pattern while DRAIN shows data
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_rdy = 1'b1;
        1: out_rdy = ($urandom_range(0, 9) < 7);
        default: begin
          if (out_vld && pat_q.size() != 0) out_rdy = pat_q.pop_front();
          else out_rdy = 1'b1;
        end
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic       prev_vld = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [1:0] e;

  always @(negedge clk) begin
    if (rst) begin
      prev_vld   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_vld", 32'(out_vld), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_vld && prev_vld) check("rx_ack_in_drain", 32'(rx_ack), 32'd0);
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0)
          fail_now("unexpected_beat", $sformatf("got out_data %0h, required no beat", out_data));
        else
          check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      if (frame_ok) begin
        if (evt_q.size() == 0) fail_now("unexpected_ok", "got frame_ok, required none");
        else begin
          e = evt_q.pop_front();
          check("frame_ok_expected", 32'(e == 2'd0), 32'd1);
        end
      end
      if (frame_err) begin
        if (evt_q.size() == 0)
          fail_now("unexpected_err", $sformatf("got frame_err code %0d, required none", err_code));
        else begin
          e = evt_q.pop_front();
          check("err_code", 32'(err_code), 32'(e));
        end
      end
      prev_vld   = out_vld;
      prev_stall = out_vld && !out_rdy;
      prev_data  = out_data;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] s[$];
  logic [7:0] b;
  logic [7:0] x;
  int         len;
  int         kind;
  int         n;

  initial begin
    #2;
    check("rst_rx_ack", 32'(rx_ack), 32'd0);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_frame_ok", 32'(frame_ok), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Good 3-byte frame at full rate: beats on three consecutive cycles.
    rdy_mode = 0;
    send_frame('{HDR, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    for (int k = 0; k < 3; k++) begin
      check("drain_run", 32'(out_vld), 32'd1);
      @(posedge clk);
      #1;
    end
    check("drain_end", 32'(out_vld), 32'd0);
    wait_idle();

    // Bad checksum, then a good frame.
    send_frame('{HDR, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04});
    send_frame('{HDR, 8'h02, 8'hA5, 8'h5A, 8'hFD});
    wait_idle();

    // Length boundaries: 0 and MAXP+1 rejected, MAXP accepted.
    send_frame('{HDR, 8'h00});
    send_frame('{HDR, 8'h11});
    s = {HDR, 8'(MAXP)};
    x = 8'(MAXP);
    for (int k = 0; k < MAXP; k++) begin
      b = 8'($urandom_range(0, 255));
      s.push_back(b);
      x = x ^ b;
    end
    s.push_back(x);
    send_frame(s);
    wait_idle();

    // Inter-byte timeout, stray byte in HUNT, then a good frame.
    send_byte(HDR);
    send_byte(8'h02);
    send_byte(8'h55);
    evt_q.push_back(2'd3);
    n = 0;
    while (!frame_err && n < TO_CYC + 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("timeout_latency_in_window", 32'(n >= TO_CYC && n <= TO_CYC + 2), 32'd1);
    send_frame('{8'h33});
    send_frame('{HDR, 8'h01, 8'h42, 8'h43});
    wait_idle();

    // Stalled drain with a second frame queued behind it.
    pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    rdy_mode = 2;
    send_frame('{HDR, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    send_frame('{HDR, 8'h02, 8'h10, 8'hAA, 8'hB8});
    wait_idle();
    rdy_mode = 0;

    // Randomised frames with junk, bad lengths and corrupted checksums.
    for (int f = 0; f < 40; f++) begin
      s = {};
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        if (b == HDR) b = 8'h00;
        s.push_back(b);
      end
      kind = $urandom_range(0, 9);
      if (kind == 0) len = 0;
      else if (kind == 1) len = $urandom_range(MAXP + 1, 255);
      else len = $urandom_range(1, MAXP);
      s.push_back(HDR);
      s.push_back(8'(len));
      if (len >= 1 && len <= MAXP) begin
        x = 8'(len);
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom_range(0, 255));
          s.push_back(b);
          x = x ^ b;
        end
        if ($urandom_range(0, 4) == 0) x = x ^ 8'($urandom_range(1, 255));
        s.push_back(x);
      end
      rdy_mode = $urandom_range(0, 1);
      send_frame(s);
    end
    wait_idle();
    rdy_mode = 0;

    // Reset during PAYLOAD: everything clears, no error pulse, next frame works.
    send_byte(HDR);
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rx_ack", 32'(rx_ack), 32'd0);
    check("midrst_out_vld", 32'(out_vld), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_frame_ok", 32'(frame_ok), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_err_code", 32'(err_code), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_frame('{HDR, 8'h01, 8'h7E, 8'h7F});
    wait_idle();

    repeat (5) @(posedge clk);
    check("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("end_evt_q_empty", 32'(evt_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
